// File: rtl/io_pkg.sv
// -----------------------------------------------------------------------------
// io_pkg
// Shared types and constants for the I/O subsystem interrupt path.
//   NPORTS      : number of input ports feeding the interrupt controller
//   port_idx_t  : port index type (wraps naturally modulo NPORTS)
//   irq_state_t : request/handshake FSM states
// -----------------------------------------------------------------------------
package io_pkg;

    localparam int NPORTS = 4;
    localparam int PW     = $clog2(NPORTS);

    typedef logic [PW-1:0] port_idx_t;

    typedef enum logic [1:0] {
        IRQ_IDLE,
        IRQ_REQ,
        IRQ_SERVICE
    } irq_state_t;

    // Successor port in round-robin order; 2-bit add wraps 3 -> 0.
    function automatic port_idx_t next_port(input port_idx_t p);
        return p + port_idx_t'(1);
    endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// -----------------------------------------------------------------------------
// rr_arbiter4
// Combinational round-robin picker over four request lines. The search
// starts at ptr and wraps 3 -> 0; the first set request wins.
//   req       in  [3:0]  request lines
//   ptr       in  [1:0]  highest-priority index this round
//   gnt_idx   out [1:0]  winning index (ptr when nothing requests)
//   gnt_valid out        at least one request was set
// -----------------------------------------------------------------------------
module rr_arbiter4
    import io_pkg::*;
(
    input  logic [NPORTS-1:0] req,
    input  port_idx_t         ptr,
    output port_idx_t         gnt_idx,
    output logic              gnt_valid
);

    // Walk offsets from farthest to nearest so the nearest set request
    // (smallest offset from ptr) is the last assignment and therefore wins.
    always_comb begin
        gnt_idx   = ptr;
        gnt_valid = 1'b0;
        for (int k = NPORTS - 1; k >= 0; k--) begin
            if (req[ptr + port_idx_t'(k)]) begin
                gnt_idx   = ptr + port_idx_t'(k);
                gnt_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/io_irq_controller.sv
// -----------------------------------------------------------------------------
// io_irq_controller
// Change-detecting interrupt controller for the four I/O input ports. Each
// port keeps a previous-value register, a pending flag and a data snapshot.
// Pending, unmasked ports are arbitrated round-robin and presented to the
// core one at a time over an irq / ack / done handshake.
//   clk, reset        in        clock, synchronous active-high reset
//   in_p0..in_p3      in  [DW]  raw port values
//   mask_we           in        mask register write strobe
//   mask_wdata        in  [4]   new mask, bit i enables port i
//   irq_ack           in        core accepted current request (pulse)
//   irq_done          in        core finished handler (pulse)
//   irq               out       request to the core
//   irq_port          out [2]   port being requested / serviced
//   irq_data          out [DW]  snapshot taken for that request
//   pending           out [4]   per-port pending flags
//   busy              out       handler in service
// -----------------------------------------------------------------------------
module io_irq_controller
    import io_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DW-1:0]     in_p0,
    input  logic [DW-1:0]     in_p1,
    input  logic [DW-1:0]     in_p2,
    input  logic [DW-1:0]     in_p3,
    input  logic              mask_we,
    input  logic [NPORTS-1:0] mask_wdata,
    input  logic              irq_ack,
    input  logic              irq_done,
    output logic              irq,
    output port_idx_t         irq_port,
    output logic [DW-1:0]     irq_data,
    output logic [NPORTS-1:0] pending,
    output logic              busy
);

    logic [NPORTS-1:0][DW-1:0] in_vec;
    logic [NPORTS-1:0][DW-1:0] prev;
    logic [NPORTS-1:0][DW-1:0] snap;
    logic [NPORTS-1:0]         pend;
    logic [NPORTS-1:0]         mask;
    logic [NPORTS-1:0]         chg;
    logic [NPORTS-1:0]         ack_clr;
    logic                      primed;
    port_idx_t                 rr_ptr;

    irq_state_t state, state_nx;
    logic       ld_req;     // IDLE found a winner: latch it this edge
    logic       take_ack;   // ack accepted in REQ
    logic       take_done;  // done accepted in SERVICE

    port_idx_t  gnt_idx;
    logic       gnt_valid;

    assign in_vec  = {in_p3, in_p2, in_p1, in_p0};
    assign pending = pend;

    // ------------------------------------------------------------------
    // Change detection. Nothing is detected until prev has been loaded
    // once after reset, so the reset value of prev never looks like an
    // edge. The registered (old) mask gates detection, so a mask write on
    // the same edge as a change does not affect that change.
    // ------------------------------------------------------------------
    always_comb begin
        chg     = '0;
        ack_clr = '0;
        for (int i = 0; i < NPORTS; i++) begin
            chg[i]     = primed && (in_vec[i] != prev[i]) && mask[i];
            ack_clr[i] = take_ack && (irq_port == port_idx_t'(i));
        end
    end

    // A change on the same edge as the ack re-arms the port: set wins
    // over clear and the snapshot takes the new value.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev   <= '0;
            snap   <= '0;
            pend   <= '0;
            primed <= 1'b0;
        end else begin
            prev   <= in_vec;
            primed <= 1'b1;
            for (int i = 0; i < NPORTS; i++) begin
                if (chg[i]) begin
                    pend[i] <= 1'b1;
                    snap[i] <= in_vec[i];
                end else if (ack_clr[i]) begin
                    pend[i] <= 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Arbitration over eligible ports. Clearing a mask bit only hides the
    // port here; its pending flag survives until it is unmasked and served.
    // ------------------------------------------------------------------
    rr_arbiter4 u_arb (
        .req       (pend & mask),
        .ptr       (rr_ptr),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    // ------------------------------------------------------------------
    // Handshake FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IRQ_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        ld_req    = 1'b0;
        take_ack  = 1'b0;
        take_done = 1'b0;
        irq       = 1'b0;
        busy      = 1'b0;
        case (state)
            IRQ_IDLE: begin
                if (gnt_valid) begin
                    ld_req   = 1'b1;
                    state_nx = IRQ_REQ;
                end
            end
            // Once raised, the request is committed: masking the port
            // now does not withdraw it.
            IRQ_REQ: begin
                irq = 1'b1;
                if (irq_ack) begin
                    take_ack = 1'b1;
                    state_nx = IRQ_SERVICE;
                end
            end
            IRQ_SERVICE: begin
                busy = 1'b1;
                if (irq_done) begin
                    take_done = 1'b1;
                    state_nx  = IRQ_IDLE;
                end
            end
            default: state_nx = IRQ_IDLE;
        endcase
    end

    // Request outputs are frozen from the IDLE latch until the next one;
    // the pointer moves past the serviced port only when the handler ends.
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_port <= '0;
            irq_data <= '0;
            rr_ptr   <= '0;
            mask     <= '0;
        end else begin
            if (mask_we) begin
                mask <= mask_wdata;
            end
            if (ld_req) begin
                irq_port <= gnt_idx;
                irq_data <= snap[gnt_idx];
            end
            if (take_done) begin
                rr_ptr <= next_port(irq_port);
            end
        end
    end

endmodule

// File: tb/tb_io_irq_controller.sv
module tb_io_irq_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] pin [4];
    logic       mask_we;
    logic [3:0] mask_wdata;
    logic       irq_ack;
    logic       irq_done;
    logic       irq;
    logic [1:0] irq_port;
    logic [7:0] irq_data;
    logic [3:0] pending;
    logic       busy;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    io_irq_controller #(.DW(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_p0      (pin[0]),
        .in_p1      (pin[1]),
        .in_p2      (pin[2]),
        .in_p3      (pin[3]),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .irq_ack    (irq_ack),
        .irq_done   (irq_done),
        .irq        (irq),
        .irq_port   (irq_port),
        .irq_data   (irq_data),
        .pending    (pending),
        .busy       (busy)
    );

    // ---------------- reference model (spec rules, plain ints) ----------
    logic [7:0] m_prev [4];
    logic [7:0] m_snap [4];
    logic [3:0] m_pend;
    logic [3:0] m_mask;
    bit         m_primed;
    int         m_phase;   // 0 waiting, 1 requesting, 2 in handler
    int         m_port;
    int         m_rr;
    logic [7:0] m_data;

    task automatic model_step();
        int clr;
        bit found;
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                m_prev[i] = 8'h00;
                m_snap[i] = 8'h00;
            end
            m_pend = 4'h0; m_mask = 4'h0; m_primed = 0;
            m_phase = 0; m_port = 0; m_rr = 0; m_data = 8'h00;
            return;
        end
        clr = -1;
        found = 0;
        case (m_phase)
            0: for (int k = 0; k < 4; k++) begin
                   int j;
                   j = (m_rr + k) % 4;
                   if (!found && m_pend[j] && m_mask[j]) begin
                       found = 1; m_port = j; m_data = m_snap[j]; m_phase = 1;
                   end
               end
            1: if (irq_ack) begin clr = m_port; m_phase = 2; end
            2: if (irq_done) begin m_rr = (m_port + 1) % 4; m_phase = 0; end
            default: ;
        endcase
        if (clr >= 0) m_pend[clr] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (m_primed && pin[i] != m_prev[i] && m_mask[i]) begin
                m_pend[i] = 1'b1;
                m_snap[i] = pin[i];
            end
            m_prev[i] = pin[i];
        end
        m_primed = 1;
        if (mask_we) m_mask = mask_wdata;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: DUT and model both consume the current inputs at the
    // rising edge; outputs are compared on the falling edge.
    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("irq",      {31'd0, irq},      {31'd0, m_phase == 1});
        chk("busy",     {31'd0, busy},     {31'd0, m_phase == 2});
        chk("irq_port", {30'd0, irq_port}, 32'(m_port));
        chk("irq_data", {24'd0, irq_data}, {24'd0, m_data});
        chk("pending",  {28'd0, pending},  {28'd0, m_pend});
    endtask

    task automatic do_reset();
        reset = 1'b1; cyc();
        reset = 1'b0; cyc();   // priming cycle
    endtask

    task automatic set_mask(input logic [3:0] m);
        mask_we = 1'b1; mask_wdata = m; cyc();
        mask_we = 1'b0;
    endtask

    task automatic wait_irq(input string tag);
        int t = 0;
        while (irq !== 1'b1 && t < 12) begin cyc(); t++; end
        chk({tag, "_irq_seen"}, {31'd0, irq}, 32'd1);
    endtask

    task automatic serve(input string tag, output int port);
        wait_irq(tag);
        port = int'(irq_port);
        irq_ack = 1'b1; cyc(); irq_ack = 1'b0;
        irq_done = 1'b1; cyc(); irq_done = 1'b0;
    endtask

    initial begin
        int ord [4];
        reset = 1'b1; mask_we = 1'b0; mask_wdata = 4'h0;
        irq_ack = 1'b0; irq_done = 1'b0;
        for (int i = 0; i < 4; i++) pin[i] = 8'h00;

        // Reset state and priming
        pin[2] = 8'h5A;
        cyc();
        chk("rst_irq", {31'd0, irq}, 32'd0);
        chk("rst_pending", {28'd0, pending}, 32'd0);
        reset = 1'b0; cyc();
        set_mask(4'hF);
        for (int c = 0; c < 10; c++) begin
            cyc();
            chk("prime_quiet", {31'd0, irq}, 32'd0);
        end
        pin[2] = 8'h5B; cyc();
        chk("lat_pend", {28'd0, pending}, 32'h4);
        chk("lat_noirq", {31'd0, irq}, 32'd0);
        cyc();
        chk("lat_irq", {31'd0, irq}, 32'd1);
        chk("lat_port", {30'd0, irq_port}, 32'd2);
        chk("lat_data", {24'd0, irq_data}, 32'h5B);
        irq_ack = 1'b1; cyc(); irq_ack = 1'b0;
        irq_done = 1'b1; cyc(); irq_done = 1'b0;

        // Round-robin ordering
        do_reset();
        set_mask(4'hF);
        pin[0] = pin[0] + 8'd1; pin[1] = pin[1] + 8'd1; pin[3] = pin[3] + 8'd1;
        cyc();
        serve("rr0", ord[0]);
        wait_irq("rr1");
        ord[1] = int'(irq_port);
        irq_ack = 1'b1; cyc(); irq_ack = 1'b0;
        pin[0] = pin[0] + 8'd1; cyc();
        irq_done = 1'b1; cyc(); irq_done = 1'b0;
        serve("rr2", ord[2]);
        serve("rr3", ord[3]);
        chk("rr_order0", 32'(ord[0]), 32'd0);
        chk("rr_order1", 32'(ord[1]), 32'd1);
        chk("rr_order2", 32'(ord[2]), 32'd3);
        chk("rr_order3", 32'(ord[3]), 32'd0);

        // Masked change is discarded
        do_reset();
        set_mask(4'b1110);
        pin[0] = pin[0] + 8'd1; cyc();
        chk("mask_pend", {28'd0, pending}, 32'd0);
        for (int c = 0; c < 3; c++) cyc();
        set_mask(4'hF);
        for (int c = 0; c < 5; c++) cyc();
        chk("mask_noirq", {31'd0, irq}, 32'd0);

        // Ack collision and handshake misuse
        pin[1] = 8'h10;
        do_reset();
        set_mask(4'hF);
        pin[1] = 8'h11; cyc(); cyc();
        chk("col_req_data", {24'd0, irq_data}, 32'h11);
        irq_done = 1'b1; cyc(); irq_done = 1'b0;
        chk("done_in_req", {31'd0, irq}, 32'd1);
        irq_ack = 1'b1; pin[1] = 8'h22; cyc(); irq_ack = 1'b0;
        chk("col_pend1", {31'd0, pending[1]}, 32'd1);
        chk("col_keep", {24'd0, irq_data}, 32'h11);
        irq_ack = 1'b1; cyc(); irq_ack = 1'b0;
        chk("ack_in_svc", {31'd0, busy}, 32'd1);
        irq_done = 1'b1; cyc(); irq_done = 1'b0;
        wait_irq("col2");
        chk("col_next_data", {24'd0, irq_data}, 32'h22);
        chk("col_next_port", {30'd0, irq_port}, 32'd1);

        // Reset while in service
        irq_ack = 1'b1; cyc(); irq_ack = 1'b0;
        pin[3] = pin[3] + 8'd1; cyc();
        chk("svc_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1; cyc();
        chk("rsvc_busy", {31'd0, busy}, 32'd0);
        chk("rsvc_irq", {31'd0, irq}, 32'd0);
        chk("rsvc_pend", {28'd0, pending}, 32'd0);
        reset = 1'b0; cyc();
        pin[3] = pin[3] + 8'd1; cyc(); cyc();
        chk("rsvc_mask0", {28'd0, pending}, 32'd0);

        // Randomized traffic against the model
        set_mask(4'hF);
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 299) == 0);
            for (int i = 0; i < 4; i++)
                if ($urandom_range(0, 5) == 0) pin[i] = 8'($urandom);
            mask_we    = ($urandom_range(0, 19) == 0);
            mask_wdata = $urandom_range(0, 1) ? 4'hF : 4'($urandom);
            irq_ack    = ($urandom_range(0, 2) == 0);
            irq_done   = ($urandom_range(0, 2) == 0);
            cyc();
        end
        reset = 1'b0; mask_we = 1'b0; irq_ack = 1'b0; irq_done = 1'b0;
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
